alu_seq: RTL and testbench

Sequential, parametrised successor to the core's combinational ALU. It executes the RV32I register/immediate ALU operations in one cycle and adds the RV32M multiply/divide group as iterative multi-cycle operations. It sits in the execute stage and talks to the core state machine through a start/busy/done handshake. The core stalls while `busy` is high and latches `result` on `done`.

---
 rtl/alu_seq_pkg.sv | 48 ++++
 rtl/alu_comb.sv | 41 ++++
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op-codes, FSM encoding and M-group decode helpers for alu_seq.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_seq_pkg;

  // Base group, indexed by funct3
  localparam logic [2:0] ALU_OP_ADD  = 3'd0;
  localparam logic [2:0] ALU_OP_SLL  = 3'd1;
  localparam logic [2:0] ALU_OP_SLT  = 3'd2;
  localparam logic [2:0] ALU_OP_SLTU = 3'd3;
  localparam logic [2:0] ALU_OP_XOR  = 3'd4;
  localparam logic [2:0] ALU_OP_SRL  = 3'd5;
  localparam logic [2:0] ALU_OP_OR   = 3'd6;
  localparam logic [2:0] ALU_OP_AND  = 3'd7;

  // M group, indexed by funct3
  localparam logic [2:0] MDU_OP_MUL    = 3'd0;
  localparam logic [2:0] MDU_OP_MULH   = 3'd1;
  localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
  localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
  localparam logic [2:0] MDU_OP_DIV    = 3'd4;
  localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
  localparam logic [2:0] MDU_OP_REM    = 3'd6;
  localparam logic [2:0] MDU_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic mdu_signed_a(input logic [2:0] op);
    return op[2] ? !op[0] : ((op == MDU_OP_MULH) || (op == MDU_OP_MULHSU));
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM
  function automatic logic mdu_signed_b(input logic [2:0] op);
    return op[2] ? !op[0] : (op == MDU_OP_MULH);
  endfunction

  // REM/REMU return the remainder, whose sign follows the dividend
  function automatic logic mdu_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational RV32I-style base ALU, WIDTH-generic.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic             is_alt_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sra_res;

  // Only the low log2(WIDTH) bits of the shift operand count
  assign shamt   = b_i[SHW-1:0];
  // Kept in its own signal so the arithmetic shift is not demoted to logical
  assign sra_res = $signed(a_i) >>> shamt;

  // Base-group operation select
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_OP_ADD:  y_o = is_alt_i ? (a_i - b_i) : (a_i + b_i);
      ALU_OP_SLL:  y_o = a_i << shamt;
      ALU_OP_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_OP_SLTU: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_OP_XOR:  y_o = a_i ^ b_i;
      ALU_OP_SRL:  y_o = is_alt_i ? sra_res : (a_i >> shamt);
      ALU_OP_OR:   y_o = a_i | b_i;
      ALU_OP_AND:  y_o = a_i & b_i;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle base ops, iterative RV32M multiply/divide.
// Latency: base/special 1 cycle; MUL WIDTH/MUL_STEP+1; DIV WIDTH+1 cycles.
// Backpressure: start ignored while busy; kill aborts silently, no queueing.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 32,  // power of two, 8..64
  parameter int MUL_STEP = 1    // 1, 2 or 4; must divide WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic             is_m,
  input  logic [2:0]       alu_op,
  input  logic             is_alt,
  input  logic [WIDTH-1:0] source,
  input  logic [WIDTH-1:0] arg_1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW    = $clog2(WIDTH) + 1;
  localparam int N_MUL = WIDTH / MUL_STEP;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // mul: {partial, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]   dvs_q, dvs_d;       // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_q, cnt_d;       // iterations remaining
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;       // final result needs negation
  logic [WIDTH-1:0]   result_q, result_d;

  // Start-time decode
  logic             accept, op_single, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b, alu_y, special_res, single_res;

  // Iteration datapath
  logic [WIDTH+MUL_STEP-1:0] mul_sum;
  logic [2*WIDTH-1:0]        mul_nxt, mul_prod, div_nxt;
  logic [WIDTH:0]            div_trial;
  logic [WIDTH-1:0]          mul_res, div_val, div_res;

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .op_i     (alu_op),
    .is_alt_i (is_alt),
    .a_i      (source),
    .b_i      (arg_1),
    .y_o      (alu_y)
  );

  // A new op is taken when idle or in the done cycle; kill always wins
  assign accept   = start && !kill && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
  assign a_neg    = mdu_signed_a(alu_op) & source[WIDTH-1];
  assign b_neg    = mdu_signed_b(alu_op) & arg_1[WIDTH-1];
  assign mag_a    = a_neg ? -source : source;
  assign mag_b    = b_neg ? -arg_1 : arg_1;
  assign div_zero = (arg_1 == '0);
  assign div_ovf  = !alu_op[0] && (source == MOST_NEG) && (arg_1 == '1);
  // Divide corner cases are answered immediately instead of iterating
  assign op_single   = !is_m || (alu_op[2] && (div_zero || div_ovf));
  assign special_res = div_zero ? (alu_op[1] ? source : '1)
                                : (alu_op[1] ? '0 : source);
  assign single_res  = is_m ? special_res : alu_y;

  // One shift-add step: add MUL_STEP partial products, then shift right
  always_comb begin
    mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
    for (int i = 0; i < MUL_STEP; i++) begin
      if (acc_q[i]) mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, dvs_q} << i);
    end
  end
  assign mul_nxt  = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};
  assign mul_prod = neg_q ? -mul_nxt : mul_nxt;
  assign mul_res  = (op_q == MDU_OP_MUL) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  always_comb begin
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
    if (!div_trial[WIDTH]) div_nxt = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else                   div_nxt = {acc_q[2*WIDTH-2:0], 1'b0};
  end
  assign div_val = op_q[1] ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];
  assign div_res = neg_q ? -div_val : div_val;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; FINISH behaves like IDLE so back-to-back starts are taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (op_single)      state_d = ST_FINISH;
          else if (alu_op[2]) state_d = ST_DIV;
          else                state_d = ST_MUL;
        end
      end
      ST_MUL, ST_DIV: if (cnt_q == CW'(1)) state_d = ST_FINISH;
      default:        state_d = ST_IDLE;
    endcase
    if (kill) state_d = ST_IDLE;
  end

  // FSM outputs: result is already registered when FINISH is entered
  always_comb begin
    busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    done = (state_q == ST_FINISH);
  end
  assign result = result_q;

  // Datapath next state: capture at start, iterate, sign-correct on the last step
  always_comb begin
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (accept) begin
      op_d  = alu_op;
      dvs_d = mag_b;
      acc_d = {{WIDTH{1'b0}}, mag_a};
      neg_d = mdu_is_rem(alu_op) ? a_neg : (a_neg ^ b_neg);
      cnt_d = '0;
      if (op_single)      result_d = single_res;
      else if (alu_op[2]) cnt_d    = CW'(WIDTH);
      else                cnt_d    = CW'(N_MUL);
    end else if (kill) begin
      cnt_d = '0;
    end else if (state_q == ST_MUL) begin
      acc_d = mul_nxt;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) result_d = mul_res;
    end else if (state_q == ST_DIV) begin
      acc_d = div_nxt;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) result_d = div_res;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32, MUL_STEP=1 and MUL_STEP=4.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W       = 32;
  localparam int TIMEOUT = 60;

  logic         clk;
  logic         reset, start1, start4, kill, is_m, is_alt;
  logic [2:0]   alu_op;
  logic [W-1:0] source, arg_1;
  logic         busy1, done1, busy4, done4;
  logic [W-1:0] result1, result4;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W), .MUL_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .kill(kill), .is_m(is_m),
    .alu_op(alu_op), .is_alt(is_alt), .source(source), .arg_1(arg_1),
    .busy(busy1), .done(done1), .result(result1)
  );

  alu_seq #(.WIDTH(W), .MUL_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .kill(kill), .is_m(is_m),
    .alu_op(alu_op), .is_alt(is_alt), .source(source), .arg_1(arg_1),
    .busy(busy4), .done(done4), .result(result4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic cur_done(input int sel);
    return (sel == 1) ? done1 : done4;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 1) ? busy1 : busy4;
  endfunction

  function automatic logic [W-1:0] cur_result(input int sel);
    return (sel == 1) ? result1 : result4;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op at the current negedge; inputs are scrambled after the start edge
  task automatic launch(input int sel, input logic m, input logic [2:0] op, input logic alt,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] exp);
    is_m = m; alu_op = op; is_alt = alt; source = a; arg_1 = b;
    if (push) exp_q.push_back(exp);
    if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    is_m = 1'($urandom); alu_op = 3'($urandom); is_alt = 1'($urandom);
    source = $urandom; arg_1 = $urandom;
  endtask

  // Count cycles from the start edge to done; optionally poke a stray start at cycle inj
  task automatic wait_done(input string tag, input int sel, input int lat, input int inj);
    int n = 1;
    int nbusy = 0;
    logic [W-1:0] exp;
    while (!cur_done(sel) && n < TIMEOUT) begin
      if (cur_busy(sel)) nbusy++;
      if (n == inj) begin
        is_m = 1'b0; alu_op = ALU_OP_ADD; is_alt = 1'b0; source = 1; arg_1 = 1;
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
      end
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      n++;
    end
    if (cur_busy(sel)) nbusy++;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    else exp = 'x;
    check({tag, " latency"}, W'(n), W'(lat));
    check({tag, " busy cycles"}, W'(nbusy), W'(lat - 1));
    check({tag, " result"}, cur_result(sel), exp);
  endtask

  task automatic run(input string tag, input int sel, input logic m, input logic [2:0] op,
                     input logic alt, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp, input int lat);
    launch(sel, m, op, alt, a, b, 1'b1, exp);
    wait_done(tag, sel, lat, 0);
  endtask

  initial begin
    int ndone;
    int sel;
    int lat;
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; kill = 1'b0;
    is_m = 1'b0; alu_op = '0; is_alt = 1'b0; source = '0; arg_1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy1",   W'(busy1), '0);
    check("reset done1",   W'(done1), '0);
    check("reset result1", result1,   '0);
    check("reset busy4",   W'(busy4), '0);
    check("reset done4",   W'(done4), '0);
    check("reset result4", result4,   '0);

    // Base group, single cycle
    run("ADD",  1, 1'b0, ALU_OP_ADD,  1'b0, 32'h7FFFFFFF, 32'h1,  32'h80000000, 1);
    run("SUB",  1, 1'b0, ALU_OP_ADD,  1'b1, 32'd5,        32'd7,  32'hFFFFFFFE, 1);
    run("SRA",  1, 1'b0, ALU_OP_SRL,  1'b1, 32'h80000000, 32'h24, 32'hF8000000, 1);
    run("SRL",  1, 1'b0, ALU_OP_SRL,  1'b0, 32'h80000000, 32'h24, 32'h08000000, 1);
    run("SLL",  1, 1'b0, ALU_OP_SLL,  1'b0, 32'd3,        32'h21, 32'd6,        1);
    run("SLT",  1, 1'b0, ALU_OP_SLT,  1'b0, 32'hFFFFFFFF, 32'd1,  32'd1,        1);
    run("SLTU", 1, 1'b0, ALU_OP_SLTU, 1'b0, 32'hFFFFFFFF, 32'd1,  32'd0,        1);

    // Multiply family on both step sizes
    for (int s = 0; s < 2; s++) begin
      sel = (s == 0) ? 1 : 4;
      lat = (s == 0) ? 33 : 9;
      run("MULH -1*-1",  sel, 1'b1, MDU_OP_MULH,   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        lat);
      run("MULHU",       sel, 1'b1, MDU_OP_MULHU,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, lat);
      run("MULHSU",      sel, 1'b1, MDU_OP_MULHSU, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, lat);
      run("MUL 7*-3",    sel, 1'b1, MDU_OP_MUL,    1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, lat);
      run("MULH min*min", sel, 1'b1, MDU_OP_MULH,  1'b0, 32'h80000000, 32'h80000000, 32'h40000000, lat);
    end

    // Divide family
    run("DIV -7/2",    1, 1'b1, MDU_OP_DIV,  1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("REM -7/2",    1, 1'b1, MDU_OP_REM,  1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("DIVU 100/7",  1, 1'b1, MDU_OP_DIVU, 1'b0, 32'd100,      32'd7, 32'd14,       33);
    run("REMU 100/7",  1, 1'b1, MDU_OP_REMU, 1'b0, 32'd100,      32'd7, 32'd2,        33);
    run("DIVU4 100/7", 4, 1'b1, MDU_OP_DIVU, 1'b0, 32'd100,      32'd7, 32'd14,       33);
    run("DIVU min/-1", 1, 1'b1, MDU_OP_DIVU, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);

    // Special cases resolve in one cycle
    run("DIV x/0",     1, 1'b1, MDU_OP_DIV,  1'b0, 32'd5,        32'd0, 32'hFFFFFFFF, 1);
    run("DIVU x/0",    1, 1'b1, MDU_OP_DIVU, 1'b0, 32'd5,        32'd0, 32'hFFFFFFFF, 1);
    run("REMU x/0",    1, 1'b1, MDU_OP_REMU, 1'b0, 32'h1234,     32'd0, 32'h1234,     1);
    run("REM -7/0",    1, 1'b1, MDU_OP_REM,  1'b0, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);
    run("DIV ovf",     1, 1'b1, MDU_OP_DIV,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("REM ovf",     1, 1'b1, MDU_OP_REM,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Stray start while busy is dropped
    launch(1, 1'b1, MDU_OP_DIVU, 1'b0, 32'd1000, 32'd3, 1'b1, 32'd333);
    wait_done("DIVU ignore start", 1, 33, 5);

    // Back-to-back: new op issued in the done cycle
    launch(1, 1'b1, MDU_OP_DIVU, 1'b0, 32'd100, 32'd7, 1'b1, 32'd14);
    wait_done("b2b first", 1, 33, 0);
    launch(1, 1'b0, ALU_OP_ADD, 1'b0, 32'd2, 32'd3, 1'b1, 32'd5);
    wait_done("b2b second", 1, 1, 0);

    // Kill at T+10: no done, result keeps 5
    launch(1, 1'b1, MDU_OP_MULHU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy", W'(busy1), '0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1) ndone++;
      @(negedge clk);
    end
    check("kill done count", W'(ndone), '0);
    check("kill result", result1, 32'd5);

    // Async reset between edges during a multiply
    launch(4, 1'b1, MDU_OP_MULHU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async rst busy4",   W'(busy4), '0);
    check("async rst done4",   W'(done4), '0);
    check("async rst result4", result4,   '0);
    check("async rst result1", result1,   '0);
    @(negedge clk);
    reset = 1'b0;
    run("post-reset MUL",   4, 1'b1, MDU_OP_MUL,   1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 9);
    run("post-reset MULHU", 1, 1'b1, MDU_OP_MULHU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);

    check("scoreboard empty", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
